// File: rtl/reservation_station_pkg.sv
// Shared widths, RV32I opcode constants and the reservation-station entry record.
package reservation_station_pkg;
  localparam int ROB_WID  = 4;
  localparam int DATA_WID = 32;
  localparam int ADDR_WID = 32;
  localparam int RS_SIZE  = 16;
  localparam int RS_BITS  = 4;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  typedef struct packed {
    logic                busy;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                funct7;
    logic                rdy1;
    logic [DATA_WID-1:0] val1;
    logic [ROB_WID-1:0]  tag1;
    logic                rdy2;
    logic [DATA_WID-1:0] val2;
    logic [ROB_WID-1:0]  tag2;
    logic [DATA_WID-1:0] imm;
    logic [ADDR_WID-1:0] pc;
    logic [ROB_WID-1:0]  rob_pos;
  } rs_entry_t;
endpackage

// File: rtl/reservation_station_prio_enc.sv
// Lowest-index priority encoder: vld when any request is set, idx of the lowest one.
module rs_prio_enc
  import reservation_station_pkg::*;
#(
  parameter int N = RS_SIZE,
  parameter int W = RS_BITS
) (
  input  logic [N-1:0] req,
  output logic         vld,
  output logic [W-1:0] idx
);
  always_comb begin
    vld = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = W'(i);
  end
endmodule

// File: rtl/reservation_station.sv
// Out-of-order holding buffer for ALU/branch/jump ops: issue, CDB wakeup, single dispatch.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE  = reservation_station_pkg::RS_SIZE,
  parameter int RS_BITS  = reservation_station_pkg::RS_BITS,
  parameter int ROB_BITS = ROB_WID
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                rs_en,
  input  logic [ROB_BITS-1:0] iss_rob_pos,
  input  logic [6:0]          iss_opcode,
  input  logic [2:0]          iss_funct3,
  input  logic                iss_funct7,
  input  logic                iss_rs1_rdy,
  input  logic [31:0]         iss_rs1_val,
  input  logic [ROB_BITS-1:0] iss_rs1_rob_pos,
  input  logic                iss_rs2_rdy,
  input  logic [31:0]         iss_rs2_val,
  input  logic [ROB_BITS-1:0] iss_rs2_rob_pos,
  input  logic [31:0]         iss_imm,
  input  logic [31:0]         iss_pc,
  output logic                rs_full,
  input  logic                alu_done,
  input  logic [31:0]         alu_res,
  input  logic [ROB_BITS-1:0] alu_res_rob_pos,
  input  logic                lsb_done,
  input  logic [31:0]         lsb_res,
  input  logic [ROB_BITS-1:0] lsb_res_rob_pos,
  output logic                alu_en,
  output logic [6:0]          alu_opcode,
  output logic [2:0]          alu_funct3,
  output logic                alu_funct7,
  output logic [31:0]         alu_val1,
  output logic [31:0]         alu_val2,
  output logic [31:0]         alu_imm,
  output logic [31:0]         alu_pc,
  output logic [ROB_BITS-1:0] alu_rob_pos
);
  rs_entry_t ent_q [RS_SIZE];
  rs_entry_t ent_d [RS_SIZE];
  rs_entry_t out_q, out_d;
  logic      alu_en_q, alu_en_d;

  logic [RS_SIZE-1:0] busy_vec, ready_vec;
  logic               free_vld, ready_vld;
  logic [RS_BITS-1:0] free_idx, ready_idx;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy & ent_q[i].rdy1 & ent_q[i].rdy2;
    end
  end

  assign rs_full = &busy_vec;

  rs_prio_enc #(.N(RS_SIZE), .W(RS_BITS)) u_free_enc (
    .req(~busy_vec), .vld(free_vld), .idx(free_idx)
  );
  rs_prio_enc #(.N(RS_SIZE), .W(RS_BITS)) u_ready_enc (
    .req(ready_vec), .vld(ready_vld), .idx(ready_idx)
  );

  always_comb begin
    ent_d    = ent_q;
    out_d    = out_q;
    alu_en_d = alu_en_q;
    if (rdy) begin
      if (rollback) begin
        for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
        alu_en_d = 1'b0;
      end else begin
        // Wakeup looks only at registered busy entries; the ALU bus wins a tie.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent_q[i].busy && !ent_q[i].rdy1) begin
            if (alu_done && alu_res_rob_pos == ent_q[i].tag1) begin
              ent_d[i].rdy1 = 1'b1;
              ent_d[i].val1 = alu_res;
            end else if (lsb_done && lsb_res_rob_pos == ent_q[i].tag1) begin
              ent_d[i].rdy1 = 1'b1;
              ent_d[i].val1 = lsb_res;
            end
          end
          if (ent_q[i].busy && !ent_q[i].rdy2) begin
            if (alu_done && alu_res_rob_pos == ent_q[i].tag2) begin
              ent_d[i].rdy2 = 1'b1;
              ent_d[i].val2 = alu_res;
            end else if (lsb_done && lsb_res_rob_pos == ent_q[i].tag2) begin
              ent_d[i].rdy2 = 1'b1;
              ent_d[i].val2 = lsb_res;
            end
          end
        end
        alu_en_d = ready_vld;
        if (ready_vld) begin
          out_d                = ent_q[ready_idx];
          ent_d[ready_idx].busy = 1'b0;
        end
        // free_idx is never busy, so it cannot collide with the dispatched slot.
        if (rs_en && free_vld) begin
          ent_d[free_idx].busy    = 1'b1;
          ent_d[free_idx].opcode  = iss_opcode;
          ent_d[free_idx].funct3  = iss_funct3;
          ent_d[free_idx].funct7  = iss_funct7;
          ent_d[free_idx].rdy1    = iss_rs1_rdy;
          ent_d[free_idx].val1    = iss_rs1_val;
          ent_d[free_idx].tag1    = iss_rs1_rob_pos;
          ent_d[free_idx].rdy2    = iss_rs2_rdy;
          ent_d[free_idx].val2    = iss_rs2_val;
          ent_d[free_idx].tag2    = iss_rs2_rob_pos;
          ent_d[free_idx].imm     = iss_imm;
          ent_d[free_idx].pc      = iss_pc;
          ent_d[free_idx].rob_pos = iss_rob_pos;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      out_q    <= '0;
      alu_en_q <= 1'b0;
    end else begin
      ent_q    <= ent_d;
      out_q    <= out_d;
      alu_en_q <= alu_en_d;
    end
  end

  always_ff @(posedge clk)
    if (!rst && rdy && !rollback && rs_en)
      assert (!rs_full) else $error("reservation_station: issue while full dropped");

  assign alu_en      = alu_en_q;
  assign alu_opcode  = out_q.opcode;
  assign alu_funct3  = out_q.funct3;
  assign alu_funct7  = out_q.funct7;
  assign alu_val1    = out_q.val1;
  assign alu_val2    = out_q.val2;
  assign alu_imm     = out_q.imm;
  assign alu_pc      = out_q.pc;
  assign alu_rob_pos = out_q.rob_pos;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with hand-computed expectations.
module tb_reservation_station;
  logic        clk = 1'b0;
  logic        rst, rdy, rollback, rs_en;
  logic [3:0]  iss_rob_pos, iss_rs1_rob_pos, iss_rs2_rob_pos;
  logic [6:0]  iss_opcode;
  logic [2:0]  iss_funct3;
  logic        iss_funct7, iss_rs1_rdy, iss_rs2_rdy;
  logic [31:0] iss_rs1_val, iss_rs2_val, iss_imm, iss_pc;
  logic        rs_full;
  logic        alu_done, lsb_done;
  logic [31:0] alu_res, lsb_res;
  logic [3:0]  alu_res_rob_pos, lsb_res_rob_pos;
  logic        alu_en;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rs_en(rs_en),
    .iss_rob_pos(iss_rob_pos), .iss_opcode(iss_opcode), .iss_funct3(iss_funct3),
    .iss_funct7(iss_funct7), .iss_rs1_rdy(iss_rs1_rdy), .iss_rs1_val(iss_rs1_val),
    .iss_rs1_rob_pos(iss_rs1_rob_pos), .iss_rs2_rdy(iss_rs2_rdy), .iss_rs2_val(iss_rs2_val),
    .iss_rs2_rob_pos(iss_rs2_rob_pos), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .rs_full(rs_full),
    .alu_done(alu_done), .alu_res(alu_res), .alu_res_rob_pos(alu_res_rob_pos),
    .lsb_done(lsb_done), .lsb_res(lsb_res), .lsb_res_rob_pos(lsb_res_rob_pos),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] rob, input logic [6:0] opc,
                       input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                       input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                       input logic [31:0] imm);
    rs_en = 1'b1; iss_rob_pos = rob; iss_opcode = opc; iss_funct3 = 3'd0; iss_funct7 = 1'b0;
    iss_rs1_rdy = r1; iss_rs1_val = v1; iss_rs1_rob_pos = t1;
    iss_rs2_rdy = r2; iss_rs2_val = v2; iss_rs2_rob_pos = t2;
    iss_imm = imm; iss_pc = 32'h1000 + {28'd0, rob} * 4;
    step();
    rs_en = 1'b0;
  endtask

  task automatic bcast_alu(input logic [3:0] tag, input logic [31:0] res);
    alu_done = 1'b1; alu_res_rob_pos = tag; alu_res = res;
    step();
    alu_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; rs_en = 1'b0;
    iss_rob_pos = '0; iss_opcode = '0; iss_funct3 = '0; iss_funct7 = 1'b0;
    iss_rs1_rdy = 1'b0; iss_rs1_val = '0; iss_rs1_rob_pos = '0;
    iss_rs2_rdy = 1'b0; iss_rs2_val = '0; iss_rs2_rob_pos = '0;
    iss_imm = '0; iss_pc = '0;
    alu_done = 1'b0; alu_res = '0; alu_res_rob_pos = '0;
    lsb_done = 1'b0; lsb_res = '0; lsb_res_rob_pos = '0;
    step(); step();
    chk("rst_full", 32'(rs_full), 32'd0);
    chk("rst_en", 32'(alu_en), 32'd0);
    chk("rst_val1", alu_val1, 32'd0);
    rst = 1'b0;
    step();

    // ADDI rob 3 with both operands ready: dispatch one edge after capture
    issue(4'd3, 7'b0010011, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 32'd7);
    chk("addi_early", 32'(alu_en), 32'd0);
    step();
    chk("addi_en", 32'(alu_en), 32'd1);
    chk("addi_val1", alu_val1, 32'd5);
    chk("addi_imm", alu_imm, 32'd7);
    chk("addi_rob", 32'(alu_rob_pos), 32'd3);
    chk("addi_op", 32'(alu_opcode), 32'h13);
    chk("addi_pc", alu_pc, 32'h100c);
    step();
    chk("addi_done", 32'(alu_en), 32'd0);

    // ADD rob 2, rs1 waits on tag 1
    issue(4'd2, 7'b0110011, 1'b0, 32'd0, 4'd1, 1'b1, 32'd9, 4'd0, 32'd0);
    chk("add_wait0", 32'(alu_en), 32'd0);
    step();
    chk("add_wait1", 32'(alu_en), 32'd0);
    bcast_alu(4'd1, 32'h10);
    chk("add_wait2", 32'(alu_en), 32'd0);
    step();
    chk("add_en", 32'(alu_en), 32'd1);
    chk("add_val1", alu_val1, 32'h10);
    chk("add_val2", alu_val2, 32'd9);
    chk("add_rob", 32'(alu_rob_pos), 32'd2);

    // Two entries wait on tag 4 via the LSB bus; entry 0 goes first
    issue(4'd5, 7'b0110011, 1'b0, 32'd0, 4'd4, 1'b1, 32'd1, 4'd0, 32'd0);
    issue(4'd6, 7'b0110011, 1'b0, 32'd0, 4'd4, 1'b1, 32'd2, 4'd0, 32'd0);
    lsb_done = 1'b1; lsb_res_rob_pos = 4'd4; lsb_res = 32'hAB;
    step();
    lsb_done = 1'b0;
    chk("lsb_wait", 32'(alu_en), 32'd0);
    step();
    chk("lsb_en0", 32'(alu_en), 32'd1);
    chk("lsb_rob0", 32'(alu_rob_pos), 32'd5);
    chk("lsb_val0", alu_val1, 32'hAB);
    step();
    chk("lsb_en1", 32'(alu_en), 32'd1);
    chk("lsb_rob1", 32'(alu_rob_pos), 32'd6);
    chk("lsb_val1", alu_val1, 32'hAB);
    chk("lsb_val2", alu_val2, 32'd2);
    step();
    chk("lsb_idle", 32'(alu_en), 32'd0);

    // Fill all 16 slots; entry i waits on tag i
    for (int i = 0; i < 16; i++) begin
      issue(4'(i), 7'b0110011, 1'b0, 32'd0, 4'(i), 1'b1, 32'd0, 4'd0, 32'd0);
      if (i == 14) chk("full_15", 32'(rs_full), 32'd0);
    end
    chk("full_16", 32'(rs_full), 32'd1);
    chk("full_en", 32'(alu_en), 32'd0);
    bcast_alu(4'd7, 32'h77);
    chk("full_woke", 32'(rs_full), 32'd1);
    step();
    chk("full_en7", 32'(alu_en), 32'd1);
    chk("full_rob7", 32'(alu_rob_pos), 32'd7);
    chk("full_val7", alu_val1, 32'h77);
    chk("full_drop", 32'(rs_full), 32'd0);
    issue(4'd9, 7'b0110011, 1'b0, 32'd0, 4'd9, 1'b0, 32'd0, 4'd9, 32'd0);
    chk("full_reuse", 32'(rs_full), 32'd1);

    // Rollback clears everything including pending dispatch
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    chk("rb0_full", 32'(rs_full), 32'd0);
    chk("rb0_en", 32'(alu_en), 32'd0);
    for (int i = 0; i < 5; i++)
      issue(4'(i), 7'b0110011, 1'b0, 32'd0, (i < 2) ? 4'd9 : 4'd10, 1'b1, 32'd0, 4'd0, 32'd0);
    bcast_alu(4'd9, 32'h99);
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    chk("rb_en", 32'(alu_en), 32'd0);
    chk("rb_full", 32'(rs_full), 32'd0);
    bcast_alu(4'd10, 32'hAA);
    chk("rb_old0", 32'(alu_en), 32'd0);
    step();
    chk("rb_old1", 32'(alu_en), 32'd0);
    step();
    chk("rb_old2", 32'(alu_en), 32'd0);

    // rdy stall with a ready entry
    issue(4'd12, 7'b0010011, 1'b1, 32'h55, 4'd0, 1'b1, 32'd0, 4'd0, 32'd1);
    rdy = 1'b0;
    step();
    chk("stall0", 32'(alu_en), 32'd0);
    step();
    chk("stall1", 32'(alu_en), 32'd0);
    rdy = 1'b1;
    step();
    chk("stall_en", 32'(alu_en), 32'd1);
    chk("stall_rob", 32'(alu_rob_pos), 32'd12);
    chk("stall_val", alu_val1, 32'h55);
    rdy = 1'b0;
    step();
    chk("stall_hold", 32'(alu_en), 32'd1);
    chk("stall_hrob", 32'(alu_rob_pos), 32'd12);
    rdy = 1'b1;
    step();
    chk("stall_end", 32'(alu_en), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Out-of-order holding buffer for ALU/branch/jump instructions. Sits directly downstream of the decoder.
- Accepts one issued instruction per cycle when rs_en is high and snoops the ALU and LSB result buses to wake up waiting operands.
- Dispatches at most one ready instruction per cycle to the ALU.
- Flushed entirely on rollback.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- RS_BITS, 4, log2(RS_SIZE).
- ROB_BITS, 4, ROB tag width; matches ROB_WID in def.v.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global enable; state frozen when low
- rollback  in  1  mispredict flush
- rs_en  in  1  decoder issues into this block this cycle
- iss_rob_pos  in  ROB_BITS  destination ROB tag
- iss_opcode  in  7  opcode
- iss_funct3  in  3  funct3
- iss_funct7  in  1  inst[30]
- iss_rs1_rdy  in  1  operand 1 valid
- iss_rs1_val  in  32  operand 1 value
- iss_rs1_rob_pos  in  ROB_BITS  operand 1 producer tag
- iss_rs2_rdy / iss_rs2_val / iss_rs2_rob_pos  in  1/32/ROB_BITS  operand 2, same meaning as operand 1
- iss_imm  in  32  immediate
- iss_pc  in  32  instruction PC
- rs_full  out  1  no free entry
- alu_done, alu_res, alu_res_rob_pos  in  1/32/ROB_BITS  ALU result broadcast
- lsb_done, lsb_res, lsb_res_rob_pos  in  1/32/ROB_BITS  LSB result broadcast
- alu_en  out  1  dispatch valid
- alu_opcode / alu_funct3 / alu_funct7  out  7/3/1  dispatched opcode fields
- alu_val1 / alu_val2 / alu_imm / alu_pc  out  32 each  dispatched operands
- alu_rob_pos  out  ROB_BITS  dispatched destination tag

Behaviour:
- Reset: rst is synchronous, active-high. It clears all busy bits; alu_en=0 and all alu_* outputs=0; rs_full=0.
- rdy low: no state change, outputs hold.
- rollback (rdy high): all busy bits cleared and alu_en=0 next cycle. Takes priority over issue, wakeup and dispatch in that cycle.
- rs_full: combinational, high when all RS_SIZE entries are busy. It does not account for a same-cycle dispatch.
- Issue:
  - When rs_en is high and not full, the lowest-index free entry captures all iss_* fields.
  - Operand values are taken as given; the decoder has already done same-cycle forwarding.
  - rs_en while rs_full is ignored, and a simulation assertion fires.
- Wakeup, every cycle, per busy entry and per operand:
  - If the operand is not ready and alu_done is high with a tag match, set ready and capture alu_res.
  - Else if lsb_done is high with a tag match, set ready and capture lsb_res.
  - If both buses match the same tag, the ALU bus wins (cannot legally occur).
  - A newly issued entry is not woken in its issue cycle. Its inputs already reflect that cycle's broadcasts.
- Dispatch:
  - Selection is among entries that were busy with both operands ready at the start of the cycle (registered state only).
  - The lowest-index such entry is chosen.
  - Next edge: alu_en=1, alu_* driven from that entry, entry busy cleared. Latency is one cycle from the ready state to alu_en.
  - If no entry qualifies, alu_en=0; other alu_* outputs are don't-care but hold their last value.
- A freed slot is reusable by issue in the cycle after it is freed. Issue and dispatch never target the same entry in one cycle.
- Throughput: one issue and one dispatch per cycle.

Decomposition:
- Package/def.v holds: opcode constants, ROB_WID/DATA_WID/ADDR_WID, RS_SIZE/RS_BITS, and an entry record typedef (busy, opcode, funct3, funct7, rdy1, val1, tag1, rdy2, val2, tag2, imm, pc, rob_pos).
- Sub-module: rs_prio_enc, a parameterised lowest-index priority encoder (valid + index out).
  - Instantiated twice: once on the free vector, once on the ready vector.

Test Plan:
- Reset then idle: rst high 2 cycles → rs_full=0, alu_en=0. Issue ADDI rob 3, val1=5, imm=7, both ready → alu_en=1 next cycle with alu_val1=5, alu_imm=7, alu_rob_pos=3.
- Operand wakeup: issue ADD rob 2 with rs1 waiting on tag 1 and rs2 ready=9. Two cycles later alu_done with rob_pos=1, res=0x10 → alu_en one cycle after broadcast, alu_val1=0x10, alu_val2=9. No earlier alu_en.
- LSB wakeup plus priority: entries 0 and 1 both wait on tag 4. lsb_done tag 4, res=0xAB → entry 0 dispatches first cycle, entry 1 next cycle, both val1=0xAB.
- Full: issue 16 non-ready entries → rs_full=1. Extra rs_en is ignored (assertion). Broadcast one tag → the entry dispatches and rs_full drops the next cycle.
- Rollback mid-operation: 5 entries, 2 ready, rollback pulse → next cycle alu_en=0, rs_full=0. Later broadcasts of old tags produce no dispatch.
- rdy stall: hold rdy low with a ready entry → alu_en unchanged. Raise rdy → dispatch resumes.
